// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM timebase / compare slice.
// Widths up to PWM_MAX_W bits and channel counts up to PWM_MAX_CH are supported.
package pwm_pkg;

  localparam int PWM_CNT_W  = 16;
  localparam int PWM_MAX_W  = 32;
  localparam int PWM_MAX_CH = 16;
  localparam int PWM_BUS_W  = PWM_MAX_W * PWM_MAX_CH;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  // Returns duty word idx (width w) from a zero-extended packed duty bus, low-aligned.
  function automatic logic [PWM_MAX_W-1:0] duty_word(input logic [PWM_BUS_W-1:0] bus,
                                                     input int idx,
                                                     input int w);
    return PWM_MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One compare channel: shadowed duty register and the registered PWM output.
// The output is computed from next-state counter/duty so it never lags the counter.
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             apply,
  input  logic             pol,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] cnt_nxt,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_sh_d = apply ? duty_in : duty_sh_q;
    if (enable) begin
      pwm_d = (cnt_nxt < duty_sh_d) ^ pol;
    end else begin
      pwm_d = pol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_counter_core.sv
// Shared PWM timebase (edge/center aligned) with double-buffered period, duty and mode.
// Shadow updates happen only at the period wrap, or immediately while disabled.
module pwm_counter_core
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 mode_in,
  input  logic [CNT_W-1:0]     period_in,
  input  logic [NCH*CNT_W-1:0] duty_in,
  input  logic [NCH-1:0]       pol,
  output logic [NCH-1:0]       pwm_out,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 dir_o,
  output logic                 period_evt,
  output logic                 load_pending
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 evt_q, evt_d;
  logic                 pend_q, pend_d;
  logic [CNT_W-1:0]     p_sh_q, p_sh_d;
  logic                 mode_sh_q, mode_sh_d;
  logic                 upd;
  logic                 apply;
  logic [PWM_BUS_W-1:0] duty_bus;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    upd   = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (p_sh_q == '0) begin
        cnt_d = '0;
        dir_d = 1'b0;
        upd   = 1'b1;
      end else if (mode_sh_q == PWM_EDGE) begin
        dir_d = 1'b0;
        if (cnt_q == p_sh_q) begin
          cnt_d = '0;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (!dir_q) begin
        // A period of 1 has no room to turn around, so it wraps straight to 0.
        if (cnt_q == p_sh_q) begin
          if (p_sh_q == ONE) begin
            cnt_d = '0;
            upd   = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
            dir_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == ONE) begin
          cnt_d = '0;
          dir_d = 1'b0;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end

    evt_d     = upd;
    apply     = (upd || !enable) && (pend_q || load);
    pend_d    = apply ? 1'b0 : (pend_q || load);
    p_sh_d    = apply ? period_in : p_sh_q;
    mode_sh_d = apply ? mode_in : mode_sh_q;
  end

  always_comb begin
    duty_bus                = '0;
    duty_bus[NCH*CNT_W-1:0] = duty_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      evt_q     <= 1'b0;
      pend_q    <= 1'b0;
      p_sh_q    <= '0;
      mode_sh_q <= PWM_EDGE;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      evt_q     <= evt_d;
      pend_q    <= pend_d;
      p_sh_q    <= p_sh_d;
      mode_sh_q <= mode_sh_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_w;
    assign duty_w = CNT_W'(duty_word(duty_bus, i, CNT_W));

    pwm_compare_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .apply   (apply),
      .pol     (pol[i]),
      .duty_in (duty_w),
      .cnt_nxt (cnt_d),
      .pwm_out (pwm_out[i])
    );
  end

  assign cnt_o        = cnt_q;
  assign dir_o        = dir_q;
  assign period_evt   = evt_q;
  assign load_pending = pend_q;

endmodule

// File: doc/pwm_counter_core.md
Name: pwm_counter_core

Overview:
- Multi-channel PWM timebase and compare stage. Sits directly downstream of the PWM prescaler and consumes its `tick` clock-enable.
- Runs one shared period counter, edge- or center-aligned, advanced only on `tick`.
- Produces NCH glitch-free registered PWM outputs plus a period event.
- Period, duty and mode are double-buffered: a new configuration takes effect only at a period boundary.

Parameters:
- CNT_W, 16: counter, period and duty width.
- NCH, 4: number of compare channels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  count enable from the prescaler; one clk-cycle pulse
- enable  in  1  run/stop for the timebase
- load  in  1  one-cycle strobe requesting a shadow update
- mode_in  in  1  0 = edge-aligned, 1 = center-aligned
- period_in  in  CNT_W  period value P
- duty_in  in  NCH*CNT_W  channel i duty D[i] at bits [i*CNT_W +: CNT_W]
- pol  in  NCH  per-channel polarity, not shadowed: 0 = active-high, 1 = inverted
- pwm_out  out  NCH  PWM outputs, registered
- cnt_o  out  CNT_W  current counter value
- dir_o  out  1  0 = counting up, 1 = counting down
- period_evt  out  1  one-cycle pulse when the counter restarts at 0
- load_pending  out  1  load requested but not yet applied

Behaviour:
- Reset (rst_n low at a clk edge): the following registers clear to 0 and override everything else:
  - cnt, dir, period_evt, load_pending, pwm_out
  - shadow regs P_sh, D_sh[], mode_sh
- All state changes on the rising clk edge. Nothing advances unless tick=1 and enable=1.
- Edge mode, per tick:
  - If cnt==P_sh: cnt<=0 and an update event occurs.
  - Otherwise cnt<=cnt+1.
  - Period is P_sh+1 ticks; dir stays 0.
- Center mode, per tick:
  - Up: if cnt==P_sh, cnt<=P_sh-1 and dir<=1. If P_sh==1, instead cnt<=0, dir stays 0, and an update event occurs.
  - Up otherwise: cnt<=cnt+1.
  - Down: cnt<=cnt-1. When cnt==1: cnt<=0, dir<=0, and an update event occurs.
  - Period is 2*P_sh ticks.
- P_sh==0 (either mode): cnt stays 0 and an update event occurs on every tick.
- Update event:
  - period_evt=1 in the cycle where the wrapped cnt (0) first appears.
  - If load_pending=1, or load=1 in the same cycle, the inputs sampled at that edge are copied into P_sh, D_sh[] and mode_sh, and load_pending<=0.
  - New values govern from cnt=0 onward.
- Load strobe:
  - load=1 sets load_pending.
  - A repeated load before the event is harmless; the latest inputs at the event edge win.
- Disabled (enable=0):
  - cnt<=0, dir<=0, period_evt<=0.
  - A pending or incoming load is applied on the next clk edge without waiting for a tick.
  - pwm_out[i]<=pol[i] (inactive level).
- Output compare:
  - pwm_out[i] is a flop fed from next-state values, so pwm_out[i] == ((cnt_o < D_sh[i]) XOR pol[i]) holds in every cycle while enabled.
  - D_sh[i]==0 gives a constant inactive level.
  - D_sh[i] > P_sh gives a constant active level, i.e. 100% duty.
  - Comparison is unsigned, CNT_W bits.
- Mode change while running takes effect only via the shadow load, at cnt=0 with dir=0.
- Synchronous reset mid-period aborts the cycle immediately; the next period starts from cnt=0 with zeroed shadows.

Decomposition:
- Package pwm_pkg:
  - mode constants PWM_EDGE=1'b0 and PWM_CENTER=1'b1
  - CNT_W default
  - function slicing a duty word from the packed duty_in bus
- One sub-module: pwm_compare_ch, instantiated NCH times. It holds D_sh[i], the shadow copy, and the pwm_out flop.
- Counter, direction logic and load control stay in the top.

Test Plan:
- Edge, P=4, D0=2, pol=0, load then enable, tick every cycle -> cnt 0,1,2,3,4,0; pwm_out[0] 1,1,0,0,0 repeating; period_evt every 5th tick.
- Center, P=3, D1=2 -> cnt 0,1,2,3,2,1,0; dir 1 during 3→2→1; pwm_out[1] high when cnt<2; period_evt every 6 ticks.
- Double buffering: running with P=4, D0=1; at cnt=2 drive load with D0=3 -> pwm_out[0] keeps the old duty until period_evt, then is high for cnt 0..2; load_pending 1 in between.
- Boundaries: D=0 -> always inactive; D=P+1=5 -> always active; pol[2]=1 inverts; P=0 -> cnt stays 0 and period_evt on every tick.
- Tick gating: tick every 3rd clk -> cnt changes only on tick cycles; enable=0 mid-period -> cnt=0 and pwm_out=pol on the next clk.
- Reset mid-operation: rst_n low for 1 clk at cnt=3 -> all outputs 0, shadows 0; after re-load, restart from cnt=0.
